// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg -- shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, the NOP word driven on an empty output
// slot, the instruction width and the program-counter increment helper.
package if_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf -- one-entry skid register for the fetch stage.
// Captures a memory response that arrived while the output slot was full and
// stalled, and hands it back once decode drains the slot.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   load_i              capture instr_i/pc_i
//   clear_i             empty the entry (has priority over load_i)
//   instr_i, pc_i       response word and its address
//   valid_o, instr_o, pc_o  stored entry
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_q;

    // Skid entry storage: clear wins so a redirect always empties it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= 32'h0000_0000;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= 32'h0000_0000;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else begin
            valid_q <= valid_q;
            instr_q <= instr_q;
            pc_q    <= pc_q;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage with one-entry skid and redirect flush.
// Issues one request per cycle to a ready/valid instruction memory, delivers
// {instruction, pc} through a registered output slot, absorbs a single
// response during a decode stall, and discards in-flight responses after a
// branch/jump redirect.
// Optional feature: define IF_FETCH_PERF_CNT_EN to add fetch_cnt_o and
// drop_cnt_o performance counters.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-low reset
//   stall_i                         decode does not consume the slot this cycle
//   redirect_i, redirect_pc_i       flush and refetch from redirect_pc_i
//   imem_req_o, imem_addr_o         memory request (address held until ready)
//   imem_ready_i, imem_rdata_i      memory response
//   instruction_o, pc_o, valid_o    output slot (zeros when valid_o is low)
//   fetch_cnt_o, drop_cnt_o         consumed / discarded counts (optional)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [31:0]        pc_o,
    output logic               valid_o
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        drop_cnt_o
`endif
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;       // next address to fetch
    logic [31:0]        addr_q, addr_d;   // address of the current request
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        opc_q, opc_d;     // pc of the word in the slot

    logic               skid_load_s;
    logic               skid_clear_s;
    logic               skid_valid_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic [31:0]        skid_pc_s;

    if_skid_buf u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .instr_i (imem_rdata_i),
        .pc_i    (addr_q),
        .valid_o (skid_valid_s),
        .instr_o (skid_instr_s),
        .pc_o    (skid_pc_s)
    );

    // A request is outstanding in FETCH and, after a redirect, in DROP.
    assign imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DROP);
    assign imem_addr_o = addr_q;

    // Next-state, fetch address and output-slot logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        // A slot decode takes this cycle empties unless refilled below.
        if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            opc_d   = 32'h0000_0000;
        end else begin
            valid_d = valid_q;
            instr_d = instr_q;
            opc_d   = opc_q;
        end

        if (redirect_i) begin
            valid_d      = 1'b0;
            instr_d      = NOP_WORD;
            opc_d        = 32'h0000_0000;
            skid_clear_s = 1'b1;
            pc_d         = redirect_pc_i;
            // An unanswered request must still be completed by memory, so
            // the address is held and its response swallowed in DROP.
            if (imem_req_o && !imem_ready_i) begin
                state_d = ST_DROP;
                addr_d  = addr_q;
            end else begin
                state_d = ST_FETCH;
                addr_d  = redirect_pc_i;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    addr_d  = pc_q;
                end
                ST_FETCH: begin
                    if (imem_ready_i) begin
                        pc_d = pc_incr(pc_q);
                        if (valid_q && stall_i) begin
                            skid_load_s = 1'b1;
                            state_d     = ST_SKID;
                        end else begin
                            valid_d = 1'b1;
                            instr_d = imem_rdata_i;
                            opc_d   = addr_q;
                            addr_d  = pc_incr(pc_q);
                        end
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_SKID: begin
                    if (!stall_i) begin
                        valid_d      = skid_valid_s;
                        instr_d      = skid_instr_s;
                        opc_d        = skid_pc_s;
                        skid_clear_s = 1'b1;
                        state_d      = ST_FETCH;
                        addr_d       = pc_q;
                    end else begin
                        state_d = ST_SKID;
                    end
                end
                ST_DROP: begin
                    if (imem_ready_i) begin
                        state_d = ST_FETCH;
                        addr_d  = pc_q;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = pc_q;
                end
            endcase
        end
    end

    // State, address and output-slot registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            opc_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign valid_o       = valid_q;
    assign instruction_o = instr_q;
    assign pc_o          = opc_q;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;
    logic        consume_s;
    logic        drop_s;

    // A slot flushed by a redirect is not counted as consumed.
    assign consume_s = valid_q && !stall_i && !redirect_i;
    assign drop_s    = imem_ready_i &&
                       ((state_q == ST_DROP) || ((state_q == ST_FETCH) && redirect_i));

    // Wrapping performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q <= 32'h0000_0000;
            drop_cnt_q  <= 32'h0000_0000;
        end else begin
            if (consume_s) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (drop_s) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end else begin
                drop_cnt_q <= drop_cnt_q;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  hazard stall; output slot not consumed this cycle when high.
REQ-005 redirect_i  input  1  branch/jump taken; flush and refetch from redirect_pc_i.
REQ-006 redirect_pc_i  input  32  redirect target address.
REQ-007 imem_req_o  output  1  instruction memory request.
REQ-008 imem_addr_o  output  32  request address; stable while imem_req_o high and imem_ready_i low.
REQ-009 imem_ready_i  input  1  response valid this cycle; completes the outstanding request.
REQ-010 imem_rdata_i  input  32  instruction word, valid with imem_ready_i.
REQ-011 instruction_o  output  32  fetched instruction to decode register; 32'b0 when valid_o low.
REQ-012 pc_o  output  32  address of instruction_o; 32'b0 when valid_o low.
REQ-013 valid_o  output  1  output slot holds a real instruction.

Function
REQ-014 States: IDLE, FETCH, SKID, DROP; every output registered except imem_req_o, which is decoded from state.
REQ-015 Slot is consumed in any cycle where stall_i is low; a consumed slot with no new data clears valid_o, instruction_o and pc_o to zero.
REQ-016 IDLE: imem_req_o=0; unconditional move to FETCH on the next edge.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=addr_q; addr_q loads pc_q at request start and holds until imem_ready_i.
REQ-018 FETCH, ready, no redirect, slot free or consumed: slot <= {imem_rdata_i, addr_q}, valid_o=1, pc_q <= pc_q+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), new request next cycle; throughput one instruction per cycle at zero-wait memory.
REQ-019 FETCH, ready, slot full and stall_i high: response stored in one-entry skid register, pc_q advances, move to SKID.
REQ-020 SKID: imem_req_o=0; first cycle stall_i low, slot <= skid, move to FETCH.
REQ-021 redirect_i: highest priority in all states; slot and skid cleared (valid_o=0, instruction_o=0, pc_o=0) regardless of stall_i; pc_q <= redirect_pc_i.
REQ-022 Redirect in FETCH with imem_ready_i same cycle: response discarded, stay FETCH, next request to the target.
REQ-023 Redirect in FETCH without imem_ready_i: move to DROP; imem_req_o and imem_addr_o held unchanged.
REQ-024 DROP: on imem_ready_i, response discarded, move to FETCH; a further redirect in DROP overwrites pc_q, stays DROP.
REQ-025 Latency: instruction visible on instruction_o one cycle after its imem_ready_i.
REQ-026 No instruction delivered twice or skipped absent redirect; delivered pc_o sequence strictly +4.

Reset
REQ-027 rst_i low: state=IDLE, pc_q=addr_q=RESET_PC, valid_o=0, instruction_o=0, pc_o=0, skid empty, imem_req_o=0, immediately and asynchronously.
REQ-028 Reset mid-request: outstanding request abandoned; memory must tolerate withdrawn request.

Configuration
REQ-029 Macro IF_FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt_o (32, instructions consumed by decode) and drop_cnt_o (32, responses discarded via redirect), both reset to 0, wrapping.
REQ-030 Macro undefined: these ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package if_fetch_pkg holds state enum, NOP word 32'h0000_0000, instruction-width constant 32.
REQ-032 Optional sub-module if_skid_buf holds the one-entry skid register; rest in if_fetch.

Verification
REQ-033 Reset release, RESET_PC=0, zero-wait memory -> pc_o 0,4,8,12 on consecutive cycles, valid_o=1.
REQ-034 stall_i high 3 cycles during request with ready -> SKID entered, instructions at 8 and 12 each delivered exactly once after stall drops.
REQ-035 redirect_i to 32'h100 same cycle as ready for 0x10 -> 0x10 never appears; next valid pc_o=32'h100.
REQ-036 redirect_i to 32'h200 with 2-wait memory -> imem_addr_o stays on old address until ready, response dropped, next request 32'h200.
REQ-037 pc_q at 32'hFFFF_FFFC -> next request address 32'h0.
REQ-038 rst_i low mid-SKID -> all outputs zero same cycle, restart at RESET_PC; with IF_FETCH_PERF_CNT_EN, counts match delivered/dropped totals.
